// File: rtl/idli_ctl_m.sv
// Window-sequenced controller: one FSM state per 4-cycle slice window, decides fetch/branch/load-store phases.
// Outputs decode combinationally from state and slice counter; requests are level-held and sampled only at ctr=3.
module idli_ctl_m (
  input  logic       i_ctl_gck,
  input  logic       i_ctl_rst_n,
  output logic [1:0] o_ctl_ctr,
  input  logic       i_ctl_instr_vld,
  output logic       o_ctl_instr_vld,
  input  logic       i_ctl_br_req,
  output logic       o_ctl_br_ack,
  input  logic       i_ctl_mem_req,
  input  logic       i_ctl_mem_wr,
  output logic       o_ctl_mem_gnt,
  output logic       o_ctl_mem_done,
  output logic       o_ctl_sqi_redirect,
  output logic       o_ctl_sqi_wr_en,
  output logic [1:0] o_ctl_addr_sel
);

  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {
    SEL_PC  = 2'd0,
    SEL_BR  = 2'd1,
    SEL_MEM = 2'd2
  } addr_sel_e;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_RET_ADDR = 3'd1,
    S_FETCH    = 3'd2,
    S_BR_ADDR  = 3'd3,
    S_MEM_ADDR = 3'd4,
    S_MEM_DATA = 3'd5
  } state_e;

  ctr_t   r_ctr;
  state_e r_state;
  logic   r_wr;

  state_e w_state_nxt;
  logic   w_wr_nxt;
  logic   w_win_end;
  logic   w_redirect;
  logic   w_wr_en;
  logic   w_br_ack;
  logic   w_mem_gnt;
  logic   w_mem_done;
  logic   w_instr_vld;
  logic [1:0] w_addr_sel;

  assign w_win_end = (r_ctr == 2'd3);

  always_ff @(posedge i_ctl_gck or negedge i_ctl_rst_n) begin
    if (!i_ctl_rst_n) begin
      r_ctr   <= 2'd0;
      r_state <= S_INIT;
      r_wr    <= 1'b0;
    end else begin
      r_ctr   <= r_ctr + 2'd1;
      r_state <= w_state_nxt;
      r_wr    <= w_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr;
    w_redirect  = 1'b0;
    w_wr_en     = 1'b0;
    w_br_ack    = 1'b0;
    w_mem_gnt   = 1'b0;
    w_mem_done  = 1'b0;
    w_instr_vld = 1'b0;
    w_addr_sel  = SEL_PC;
    case (r_state)
      S_INIT: begin
        if (w_win_end) w_state_nxt = S_RET_ADDR;
      end
      S_RET_ADDR: begin
        w_redirect = 1'b1;
        w_addr_sel = SEL_PC;
        if (w_win_end) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // A redirect at window end makes the instruction just fetched stale.
        w_instr_vld = i_ctl_instr_vld &&
                      !(w_win_end && (i_ctl_br_req || i_ctl_mem_req));
        if (w_win_end) begin
          if (i_ctl_br_req) begin
            w_state_nxt = S_BR_ADDR;
          end else if (i_ctl_mem_req) begin
            w_state_nxt = S_MEM_ADDR;
            w_wr_nxt    = i_ctl_mem_wr;
          end
        end
      end
      S_BR_ADDR: begin
        w_redirect = 1'b1;
        w_addr_sel = SEL_BR;
        w_br_ack   = w_win_end;
        if (w_win_end) w_state_nxt = S_FETCH;
      end
      S_MEM_ADDR: begin
        w_redirect = 1'b1;
        w_addr_sel = SEL_MEM;
        w_wr_en    = r_wr;
        w_mem_gnt  = w_win_end;
        if (w_win_end) w_state_nxt = S_MEM_DATA;
      end
      S_MEM_DATA: begin
        w_addr_sel = SEL_MEM;
        w_wr_en    = r_wr;
        w_mem_done = w_win_end;
        if (w_win_end) w_state_nxt = S_RET_ADDR;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign o_ctl_ctr          = r_ctr;
  assign o_ctl_instr_vld    = w_instr_vld;
  assign o_ctl_br_ack       = w_br_ack;
  assign o_ctl_mem_gnt      = w_mem_gnt;
  assign o_ctl_mem_done     = w_mem_done;
  assign o_ctl_sqi_redirect = w_redirect;
  assign o_ctl_sqi_wr_en    = w_wr_en;
  assign o_ctl_addr_sel     = w_addr_sel;

endmodule

// File: doc/idli_ctl_m.md
IDLI_CTL_M -- requirements
Module: idli_ctl_m

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-002 i_ctl_gck  in  1  core clock; all state updates on its rising edge.
REQ-003 i_ctl_rst_n  in  1  asynchronous active-low reset.
REQ-004 o_ctl_ctr  out  2  slice counter (ctr_t) fanned out to the SQI and decode blocks.
REQ-005 i_ctl_instr_vld  in  1  SQI reports a complete 16-bit instruction.
REQ-006 o_ctl_instr_vld  out  1  gated instruction-valid to decode.
REQ-007 i_ctl_br_req  in  1  execute requests redirect to branch target; level, held until ack.
REQ-008 o_ctl_br_ack  out  1  single-cycle branch acknowledge.
REQ-009 i_ctl_mem_req  in  1  execute requests load/store; level, held until done.
REQ-010 i_ctl_mem_wr  in  1  1 = store, 0 = load; valid while i_ctl_mem_req=1.
REQ-011 o_ctl_mem_gnt  out  1  single-cycle pulse: load/store address phase completed.
REQ-012 o_ctl_mem_done  out  1  single-cycle pulse: load/store data phase completed.
REQ-013 o_ctl_sqi_redirect  out  1  SQI address-phase strobe.
REQ-014 o_ctl_sqi_wr_en  out  1  SQI write enable.
REQ-015 o_ctl_addr_sel  out  2  address source for slice mux: 0 PC, 1 branch target, 2 memory address, 3 unused.

Function
REQ-016 o_ctl_ctr SHALL increment by 1 modulo 4 every cycle out of reset; one "window" = ctr 0..3 (one 16-bit value in four 4-bit slices).
REQ-017 FSM states SHALL be INIT, RET_ADDR, FETCH, BR_ADDR, MEM_ADDR, MEM_DATA.
REQ-018 State transitions SHALL occur only on the edge where ctr goes 3->0; state is constant for a whole window.
REQ-019 INIT: all outputs except o_ctl_ctr 0; next RET_ADDR.
REQ-020 RET_ADDR: redirect=1, addr_sel=0; next FETCH.
REQ-021 FETCH: redirect=0, wr_en=0; at ctr=3: br_req=1 -> BR_ADDR; else mem_req=1 -> MEM_ADDR; else FETCH (branch has priority over memory).
REQ-022 BR_ADDR: redirect=1, addr_sel=1; br_ack=1 when ctr=3; next FETCH.
REQ-023 MEM_ADDR: redirect=1, addr_sel=2, wr_en=latched wr; mem_gnt=1 when ctr=3; next MEM_DATA.
REQ-024 i_ctl_mem_wr SHALL be latched at the FETCH->MEM_ADDR transition; later changes ignored until done.
REQ-025 MEM_DATA: redirect=0, addr_sel=2, wr_en=latched wr; mem_done=1 when ctr=3; next RET_ADDR.
REQ-026 o_ctl_instr_vld SHALL equal i_ctl_instr_vld AND state=FETCH AND NOT (ctr=3 with a pending br_req or mem_req), suppressing fetched instructions made stale by the redirect.
REQ-027 br_req asserted during MEM_ADDR/MEM_DATA/RET_ADDR SHALL be held off and serviced from the next FETCH window; no ack until BR_ADDR.
REQ-028 br_req and mem_req simultaneous at FETCH ctr=3: BR_ADDR, then FETCH for at least one window, then MEM_ADDR if mem_req still high.
REQ-029 Request deasserted before ctr=3 of FETCH SHALL not be serviced; ack/gnt/done never asserted outside their state.
REQ-030 o_ctl_sqi_wr_en SHALL be 0 in every state except MEM_ADDR/MEM_DATA of a store.

Reset
REQ-031 While i_ctl_rst_n=0: state INIT, ctr 0, latched wr 0, all outputs 0, asynchronously, including mid-transaction.
REQ-032 After release, first window SHALL be INIT (ctr 0..3), second RET_ADDR, third FETCH.
REQ-033 Reset during MEM_DATA SHALL produce no mem_done; the requester re-issues after reset.

Verification
REQ-034 Reset release, no requests -> ctr 0,1,2,3,0...; redirect=1 exactly cycles 4-7; FETCH from cycle 8; instr_vld passes through.
REQ-035 br_req=1 at cycle 9 -> BR_ADDR cycles 12-15, addr_sel=1, br_ack only cycle 15, FETCH from 16; instr_vld blocked cycles 11-15.
REQ-036 Store: mem_req=1, mem_wr=1 in FETCH cycle 8 -> MEM_ADDR 12-15 (wr_en=1, gnt at 15), MEM_DATA 16-19 (done at 19), RET_ADDR 20-23 addr_sel=0, FETCH 24.
REQ-037 Load with mem_wr toggled during MEM_DATA -> wr_en stays 0 throughout.
REQ-038 br_req and mem_req together at cycle 8 -> BR_ADDR 12-15, FETCH 16-19, MEM_ADDR 20-23; single ack, single gnt, single done.
REQ-039 Reset asserted at cycle 17 of a store -> outputs 0 same cycle, no mem_done; release replays INIT/RET_ADDR/FETCH sequence.
